uart_rx: RTL and testbench

//  Receive half of the UART controller; consumer of the serial line driven by the transmitter.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to uart_rx and uart_tx)
// and helpers that derive the baud-rate counter constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit (integer divide, remainder is absorbed by mid-bit sampling).
  function automatic int uart_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Clocks from a start-bit falling edge to the middle of the start bit.
  function automatic int uart_half_cnt(input int bit_cnt);
    return bit_cnt / 2;
  endfunction

  // Down-counter width; never narrower than one bit.
  function automatic int uart_cnt_w(input int bit_cnt);
    return (bit_cnt > 2) ? $clog2(bit_cnt) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. Reset value is a
// parameter so idle-high lines do not show a spurious edge leaving reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1. Detects the start-bit falling edge on the synchronised
// line, samples every bit at mid-bit and hands complete bytes to a one-byte
// holding register. Stop bit low -> frame_err pulse; byte completing while the
// holding register is still full -> overrun pulse (new byte dropped).
//
// Output handshake: rx_valid/rx_data form a valid/ready source. Once rx_valid
// is high it and rx_data hold until the cycle where rx_valid && rx_ready, which
// is the transfer. rx_valid is a pure register and never depends
// combinationally on rx_ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overrun,
  output uart_state_e dbg_state
);

  localparam int BIT_CNT  = uart_bit_cnt(CLK_FREQ, BAUD);
  localparam int HALF_CNT = uart_half_cnt(BIT_CNT);
  localparam int CNT_W    = uart_cnt_w(BIT_CNT);

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Synchronised line and its one-cycle delayed copy for edge detection.
  logic w_rx_s;
  logic r_rx_d;
  logic w_fall;

  // FSM, bit timing and data path.
  uart_state_e      r_state;
  uart_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_cnt_zero;
  logic             w_stop_ok;
  logic             w_stop_bad;

  // Holding register and status pulses.
  logic             r_deliver;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // Delay flop behind the synchroniser; reset high so a held-low line is not
  // mistaken for a fresh edge by this stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_d <= 1'b1;
    end else begin
      r_rx_d <= w_rx_s;
    end
  end

  // Only a high-to-low transition arms the receiver; a line stuck low (break)
  // cannot re-arm until it has gone high again.
  assign w_fall     = r_rx_d & ~w_rx_s;
  assign w_cnt_zero = (r_cnt == '0);

  // FSM state, bit counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: mid-bit sampling of start, eight data bits and stop.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_RELOAD;
        end
      end
      START: begin
        if (w_cnt_zero) begin
          if (!w_rx_s) begin
            w_state_nxt   = DATA;
            w_cnt_nxt     = BIT_RELOAD;
            w_bit_idx_nxt = 3'd0;
          end else begin
            // Line back high by mid start bit: treat as a glitch.
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_cnt_nxt              = BIT_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (w_cnt_zero) begin
          // Leave at mid stop bit so the next start edge is never missed.
          w_state_nxt = IDLE;
          w_stop_ok   = w_rx_s;
          w_stop_bad  = ~w_rx_s;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Holding register: load the finished byte the cycle after the stop sample
  // if empty or being emptied this cycle, otherwise flag overrun and keep the
  // old byte; an accept with nothing new to load clears rx_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deliver   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_deliver   <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (r_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kBd (10 clocks per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CNT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  uart_state_e dbg_state;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_both = 0;
  int n_valid_cyc = 0;
  int n_unstable = 0;
  int t_fall = 0;
  int t_rise = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Monitor on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err && overrun) n_both++;
      if (rx_valid) n_valid_cyc++;
      if (rx_valid && !prev_valid) t_rise = cyc;
      if (prev_valid && !prev_ready && rx_valid && (rx_data != prev_data)) n_unstable++;
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain_compare(input string tag);
    logic [31:0] g;
    logic [7:0]  e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = {24'h0, got_q.pop_front()};
      else g = 32'hDEAD;
      check(tag, g, {24'h0, e});
    end
    check({tag, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All drive happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CNT) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0, o0, v0, lat;
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    idle(20);

    // 1: single frame 0xA5, latency and one-cycle valid
    f0 = n_ferr; o0 = n_ovr; v0 = n_valid_cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    lat = t_rise - t_fall;
    check("t1_latency", (lat >= 97 && lat <= 99) ? 99 : lat, 99);
    check("t1_valid_cycles", n_valid_cyc - v0, 1);
    check("t1_ferr", n_ferr - f0, 0);
    check("t1_ovr", n_ovr - o0, 0);
    drain_compare("t1_byte");

    // 2: back-to-back frames
    f0 = n_ferr;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    check("t2_ferr", n_ferr - f0, 0);
    drain_compare("t2_byte");

    // 3: 3-cycle glitch then a real frame
    f0 = n_ferr; v0 = n_valid_cyc;
    rx = 1'b0;
    repeat (3) tick();
    idle(30);
    check("t3_glitch_valid", n_valid_cyc - v0, 0);
    check("t3_glitch_ferr", n_ferr - f0, 0);
    check("t3_state", dbg_state, IDLE);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(20);
    drain_compare("t3_byte");

    // 4: framing error followed by a held-low line
    f0 = n_ferr; v0 = n_valid_cyc;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (30) tick();
    check("t4_ferr", n_ferr - f0, 1);
    check("t4_valid", n_valid_cyc - v0, 0);
    check("t4_break_state", dbg_state, IDLE);
    idle(20);
    check("t4_state_after", dbg_state, IDLE);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(20);
    drain_compare("t4_byte");

    // 5: consumer stalled -> overrun on the second byte
    f0 = n_ferr; o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("t5_ovr", n_ovr - o0, 1);
    check("t5_data_held", rx_data, 8'h11);
    check("t5_valid_held", rx_valid, 1);
    check("t5_ferr", n_ferr - f0, 0);
    rx_ready = 1'b1;
    tick();
    tick();
    check("t5_valid_drop", rx_valid, 0);
    exp_q.push_back(8'h11);
    drain_compare("t5_byte");

    // 6: accept coincides with completion of the next byte
    o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h66, 1'b1);
    idle(10);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (98) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t6_valid_stays", rx_valid, 1);
        check("t6_data_new", rx_data, 8'h77);
      end
    join
    idle(20);
    check("t6_ovr", n_ovr - o0, 0);
    rx_ready = 1'b1;
    tick();
    tick();
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    drain_compare("t6_byte");

    // 6b: reset in the middle of the data bits
    f0 = n_ferr; v0 = n_valid_cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("t6_mid_data", dbg_state, DATA);
    reset = 1'b1;
    rx    = 1'b1;
    tick();
    tick();
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_state", dbg_state, IDLE);
    reset = 1'b0;
    idle(40);
    check("t6_abort_valid", n_valid_cyc - v0, 0);
    check("t6_abort_ferr", n_ferr - f0, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(20);
    drain_compare("t6_after_rst");

    check("err_same_cycle", n_both, 0);
    check("data_stable", n_unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
